// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch (T0-T2) and register-register ALU execute (T3-T5)
// with a memory wait in T1, a halt state and single-cycle illegal-opcode reporting.
module control_sequencer (
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic        mem_ready,
  input  logic [31:0] IR,
  output logic        PCout,
  output logic        MARin,
  output logic        IncPC,
  output logic        Zlowin,
  output logic        Zlowout,
  output logic        PCin,
  output logic        Read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic [3:0]  ALUop,
  output logic        done,
  output logic        illegal,
  output logic        halted
);

  typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, HALT} state_t;

  state_t     state;
  logic       first_t1;
  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic       is_alu, is_halt;
  logic       unused_ir;

  assign opcode    = IR[31:27];
  assign ra        = IR[26:23];
  assign rb        = IR[22:19];
  assign rc        = IR[18:15];
  assign is_alu    = (opcode <= 5'h0A);
  assign is_halt   = (opcode == 5'h1F);
  assign unused_ir = ^IR[14:0];

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state    <= IDLE;
      first_t1 <= 1'b0;
    end else begin
      case (state)
        IDLE: if (run) state <= T0;
        T0: begin
          state    <= T1;
          first_t1 <= 1'b1;
        end
        // PC update happens only on the first T1 cycle, however long memory stalls
        T1: begin
          first_t1 <= 1'b0;
          if (mem_ready) state <= T2;
        end
        T2: state <= T3;
        T3: begin
          if (is_halt)     state <= HALT;
          else if (is_alu) state <= T4;
          else             state <= run ? T0 : IDLE;
        end
        T4:      state <= T5;
        T5:      state <= run ? T0 : IDLE;
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    PCout   = 1'b0;
    MARin   = 1'b0;
    IncPC   = 1'b0;
    Zlowin  = 1'b0;
    Zlowout = 1'b0;
    PCin    = 1'b0;
    Read    = 1'b0;
    MDRin   = 1'b0;
    MDRout  = 1'b0;
    IRin    = 1'b0;
    Yin     = 1'b0;
    Rin     = 16'h0000;
    Rout    = 16'h0000;
    ALUop   = 4'h0;
    done    = 1'b0;
    illegal = 1'b0;
    halted  = 1'b0;
    case (state)
      T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        Zlowin = 1'b1;
      end
      T1: begin
        Zlowout = first_t1;
        PCin    = first_t1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      T3: begin
        if (is_alu) begin
          Rout = 16'h0001 << rb;
          Yin  = 1'b1;
        end else if (!is_halt) begin
          illegal = 1'b1;
        end
      end
      T4: begin
        Rout   = 16'h0001 << rc;
        ALUop  = opcode[3:0];
        Zlowin = 1'b1;
      end
      T5: begin
        Zlowout = 1'b1;
        Rin     = 16'h0001 << ra;
        done    = 1'b1;
      end
      HALT:    halted = 1'b1;
      default: ;
    endcase
  end

endmodule
